// File: rtl/srl_window_reader.sv
// rtl/srl_window_reader.sv - trigger-driven window reader over a circular delay buffer
//
// Stores a WIDTH-bit word into a 2**AW-deep circular buffer on every ce.
// A trigger in IDLE reads back win_len+1 consecutive words, starting lookback
// words behind the newest stored word, over a valid/ready stream.
//
// Optional feature macro: SRL_READER_PARITY_EN
//   defined     : buffer stores ^d with each word; q_perr flags a parity mismatch on load
//   not defined : buffer is WIDTH bits wide; q_perr is always 0
//
// Ports:
//   clock, reset_n     clock (rising edge), asynchronous active-low reset
//   ce, d              write enable and input word
//   trig               readout request, accepted only in IDLE
//   lookback, win_len  window start (words back from newest) and length minus 1
//   q, q_vld, q_rdy    output word stream; q held while q_vld=1 and q_rdy=0
//   q_last, q_perr     qualifiers of q_vld: final window word, parity error
//   busy, done         not-IDLE status, one-cycle completion pulse
//   ovf                a window word was overwritten before being read (valid with done)
//   trig_lost          trig seen while busy
module srl_window_reader #(
  parameter int WIDTH = 19,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             trig,
  input  logic [AW-1:0]    lookback,
  input  logic [AW-1:0]    win_len,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  input  logic             q_rdy,
  output logic             q_last,
  output logic             q_perr,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             trig_lost
);

  localparam int DEPTH = 2**AW;
`ifdef SRL_READER_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [MW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_adr;
  logic [AW-1:0]    r_rd_adr;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    r_len;
  logic             r_loaded;
  logic [WIDTH-1:0] r_q;
  logic             r_q_vld;
  logic             r_q_last;
  logic             r_q_perr;
  logic             r_ovf;
  logic [MW-1:0]    w_wr_word;
  logic [MW-1:0]    w_rd_word;
  logic             w_perr;
  logic             w_slot;
  logic             w_drain;

`ifdef SRL_READER_PARITY_EN
  assign w_wr_word = {^d, d};
  assign w_perr    = (^w_rd_word[WIDTH-1:0]) != w_rd_word[WIDTH];
`else
  assign w_wr_word = d;
  assign w_perr    = 1'b0;
`endif

  assign w_rd_word = r_mem[r_rd_adr];

  // r_loaded marks that the final window word is already in q; a separate flag
  // is needed because cnt cannot represent DEPTH when win_len is DEPTH-1.
  assign w_slot  = (r_state == ST_READ) && (!r_q_vld || q_rdy) && !r_loaded;
  // Any acceptance after the final load is the acceptance of the last word.
  assign w_drain = (r_state == ST_READ) && r_q_vld && q_rdy && r_loaded;

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (ce) begin
      r_mem[r_wr_adr] <= w_wr_word;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (trig) w_next_state = ST_READ;
      ST_READ: if (w_drain) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_adr <= '0;
      r_rd_adr <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_loaded <= 1'b0;
      r_q      <= '0;
      r_q_vld  <= 1'b0;
      r_q_last <= 1'b0;
      r_q_perr <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (ce) begin
        r_wr_adr <= r_wr_adr + AW'(1);
      end
      if (r_state == ST_IDLE && trig) begin
        // Uses the write pointer before this edge's write.
        r_rd_adr <= r_wr_adr - AW'(1) - lookback;
        r_cnt    <= '0;
        r_len    <= win_len;
        r_loaded <= 1'b0;
        r_ovf    <= 1'b0;
      end
      if (w_slot) begin
        r_q      <= w_rd_word[WIDTH-1:0];
        r_q_vld  <= 1'b1;
        r_q_last <= (r_cnt == r_len);
        r_q_perr <= w_perr;
        r_rd_adr <= r_rd_adr + AW'(1);
        r_cnt    <= r_cnt + AW'(1);
        if (r_cnt == r_len) begin
          r_loaded <= 1'b1;
        end
      end else if (w_drain) begin
        r_q_vld  <= 1'b0;
        r_q_last <= 1'b0;
        r_q_perr <= 1'b0;
      end
      // Writer reaching the next unread address means that word is lost.
      if (r_state == ST_READ && ce && !r_loaded && r_wr_adr == r_rd_adr) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign q         = r_q;
  assign q_vld     = r_q_vld;
  assign q_last    = r_q_last;
  assign q_perr    = r_q_perr;
  assign ovf       = r_ovf;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign trig_lost = trig && (r_state != ST_IDLE);

endmodule

// File: tb/tb_srl_window_reader.sv
// tb/tb_srl_window_reader.sv - randomized model-checked bench for srl_window_reader
module tb_srl_window_reader;

  localparam int WIDTH = 19;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             ce = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             trig = 1'b0;
  logic [AW-1:0]    lookback = '0;
  logic [AW-1:0]    win_len = '0;
  logic             q_rdy = 1'b0;
  logic [WIDTH-1:0] q;
  logic             q_vld, q_last, q_perr, busy, done, ovf, trig_lost;

  srl_window_reader #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .ce(ce), .d(d), .trig(trig),
    .lookback(lookback), .win_len(win_len), .q(q), .q_vld(q_vld),
    .q_rdy(q_rdy), .q_last(q_last), .q_perr(q_perr), .busy(busy),
    .done(done), .ovf(ovf), .trig_lost(trig_lost)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: the window is a queue of buffer addresses; one word
  // leaves the queue whenever the output register is empty or being taken.
  logic [WIDTH-1:0] mm [DEPTH];
  bit               mw [DEPTH];
  bit               mbad [DEPTH];
  int               m_wr = 0;
  int               m_a;
  int               qa[$];
  bit               m_active = 0, m_done = 0, m_vld = 0, m_last = 0;
  bit               m_ovf = 0, m_qok = 0, m_perr = 0;
  logic [WIDTH-1:0] m_q = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_wr = 0; m_active = 0; m_done = 0; m_vld = 0; m_last = 0;
      m_ovf = 0; m_perr = 0; m_q = '0; qa.delete();
    end else begin
      cyc++;
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (ce && qa.size() > 0 && m_wr == qa[0]) m_ovf = 1;
        if (!m_vld || q_rdy) begin
          if (qa.size() > 0) begin
            m_a    = qa.pop_front();
            m_q    = mm[m_a] ^ WIDTH'(mbad[m_a]);
            m_qok  = mw[m_a];
            m_perr = mbad[m_a];
            m_vld  = 1;
            m_last = (qa.size() == 0);
          end else if (m_vld) begin
            m_vld = 0; m_last = 0; m_perr = 0; m_active = 0; m_done = 1;
          end
        end
      end else if (trig) begin
        qa.delete();
        for (int k = 0; k <= int'(win_len); k++)
          qa.push_back((m_wr - 1 - int'(lookback) + k) & (DEPTH - 1));
        m_active = 1;
        m_ovf    = 0;
      end
      if (ce) begin
        mm[m_wr] = d; mw[m_wr] = 1; mbad[m_wr] = 0;
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
  end

  // Observation of accepted words and events for the literal checks.
  int acc[$];
  int first_vld = -1, done_cyc = -1, done_cnt = 0, lost_cnt = 0, perr_cnt = 0;
  bit done_ovf = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      chk("q_vld", q_vld, m_vld);
      chk("busy", busy, m_active | m_done);
      chk("done", done, m_done);
      chk("q_last", q_last, m_vld & m_last);
      chk("q_perr", q_perr, m_vld & m_perr);
      chk("trig_lost", trig_lost, trig & (m_active | m_done));
      if (m_vld && m_qok) chk("q", q, m_q);
      if (m_done) chk("ovf", ovf, m_ovf);
      if (q_vld && q_rdy) begin
        acc.push_back(int'(q));
        if (q_perr) perr_cnt++;
      end
      if (q_vld && first_vld < 0) first_vld = cyc;
      if (done) begin done_cyc = cyc; done_ovf = ovf; done_cnt++; end
      if (trig_lost) lost_cnt++;
    end
  end

  int ce_mode = 0, rdy_mode = 1, d_ctr = 0, t_cap = 0;
  bit rand_trig = 0;

  task automatic step();
    case (ce_mode)
      0: ce = 1'b0;
      1: ce = 1'b1;
      default: ce = 1'($urandom_range(0, 1));
    endcase
    d = d_ctr[WIDTH-1:0];
    case (rdy_mode)
      0: q_rdy = 1'b0;
      1: q_rdy = 1'b1;
      2: q_rdy = ~q_rdy;
      default: q_rdy = (($urandom % 4) != 0);
    endcase
    @(posedge clock);
    #1;
    if (ce) d_ctr++;
  endtask

  task automatic clear_mon();
    acc.delete();
    first_vld = -1; done_cyc = -1; done_ovf = 0;
    done_cnt = 0; lost_cnt = 0; perr_cnt = 0;
  endtask

  task automatic trigger(input int lb, input int wl);
    clear_mon();
    lookback = AW'(lb);
    win_len  = AW'(wl);
    trig = 1'b1;
    step();
    trig = 1'b0;
    t_cap = cyc;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      trig = rand_trig && (($urandom % 8) == 0);
      step();
      trig = 1'b0;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    ce_mode = 0;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    d_ctr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_q_vld", q_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", ovf, 0);
    do_reset();

    // Test 1: straight stream 7..10
    ce_mode = 1; rdy_mode = 1;
    repeat (10) step();
    trigger(2, 3);
    wait_idle(50);
    chk("t1_count", acc.size(), 4);
    for (int i = 0; i < acc.size() && i < 4; i++) chk("t1_word", acc[i], 7 + i);
    chk("t1_first_vld", first_vld, t_cap + 1);
    chk("t1_done_cyc", done_cyc, t_cap + 5);
    chk("t1_ovf", done_ovf, 0);

    // Test 2: toggling ready
    do_reset();
    ce_mode = 1; rdy_mode = 2; q_rdy = 1'b0;
    repeat (10) step();
    trigger(2, 3);
    wait_idle(50);
    chk("t2_count", acc.size(), 4);
    for (int i = 0; i < acc.size() && i < 4; i++) chk("t2_word", acc[i], 7 + i);

    // Test 3: read-pointer wrap
    do_reset();
    ce_mode = 1; rdy_mode = 1;
    repeat (17) step();
    ce_mode = 0;
    trigger(3, 2);
    wait_idle(50);
    chk("t3_count", acc.size(), 3);
    for (int i = 0; i < acc.size() && i < 3; i++) chk("t3_word", acc[i], 13 + i);
`ifdef SRL_READER_PARITY_EN
    dut.r_mem[14][0] = ~dut.r_mem[14][0];
    mbad[14] = 1;
    trigger(3, 2);
    wait_idle(50);
    chk("t6_perr_cnt", perr_cnt, 1);
    chk("t6_count", acc.size(), 3);
    if (acc.size() == 3) chk("t6_word", acc[1], 15);
`else
    chk("t6_perr_cnt", perr_cnt, 0);
`endif

    // Test 4: overrun with stalled reader, then without writes
    ce_mode = 1; rdy_mode = 0;
    trigger(15, 15);
    repeat (20) step();
    rdy_mode = 1;
    wait_idle(100);
    chk("t4_ovf", done_ovf, 1);
    chk("t4_count", acc.size(), 16);
    ce_mode = 0; rdy_mode = 0;
    trigger(15, 15);
    repeat (20) step();
    rdy_mode = 1;
    wait_idle(100);
    chk("t4b_ovf", done_ovf, 0);
    chk("t4b_count", acc.size(), 16);

    // Test 5: lost triggers in READ and DONE
    ce_mode = 1; rdy_mode = 1;
    trigger(2, 3);
    step();
    trig = 1'b1; step(); trig = 1'b0;
    step(); step(); step();
    chk("t5_in_done", done, 1);
    trig = 1'b1; step(); trig = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_lost_cnt", lost_cnt, 2);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_count", acc.size(), 4);

    // Test 5b: asynchronous reset in READ
    rdy_mode = 0;
    trigger(15, 15);
    step(); step(); step();
    #2 reset_n = 1'b0;
    #1;
    chk("t5r_q_vld", q_vld, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_q", q, 0);
    chk("t5r_q_last", q_last, 0);
    chk("t5r_ovf", ovf, 0);
    chk("t5r_done", done, 0);
    ce_mode = 0;
    step(); step();
    reset_n = 1'b1;
    clear_mon();
    step(); step(); step();
    chk("t5r_idle", busy, 0);
    chk("t5r_no_done", done_cnt, 0);

    // Randomized legal windows with random writes, ready and stray triggers
    ce_mode = 1; rdy_mode = 1;
    repeat (16) step();
    ce_mode = 2; rdy_mode = 3;
    for (int n = 0; n < 40; n++) begin
      int wl, lb;
      repeat ($urandom_range(0, 4)) step();
      wl = $urandom_range(0, 15);
      lb = $urandom_range(wl, 15);
      rand_trig = 1;
      trigger(lb, wl);
      wait_idle(400);
      rand_trig = 0;
      chk("rnd_count", acc.size(), wl + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
